// File: rtl/change_return_engine.sv
// change_return_engine
//
// Returns the credit held by a vending machine as a sequence of coins, either
// on a user request or after the machine has sat idle with credit for
// WAIT_CYCLES clock cycles. The largest coin that still fits in the remaining
// amount is offered first. Whatever cannot be paid out with the smallest coin
// is reported as the residual when the sequence ends.
//
// Ports
//   clk               rising-edge clock
//   reset_n           synchronous, active-low reset
//   i_coin_in         coin-insert strobes; any bit high counts as activity
//   i_activity        item-select strobe; counts as activity
//   i_trigger_return  user request to return the credit
//   i_total           current credit held by the machine
//   i_return_ready    coin mechanism accepts the coin being presented
//   o_return_coin     one-hot coin being returned, zero when not valid
//   o_return_valid    o_return_coin is valid
//   o_busy            a return sequence is in progress (DISPENSE or DONE)
//   o_done            one-cycle pulse at the end of a return sequence
//   o_residual        amount that could not be returned, held until next o_done
//   o_wait_time       current idle timeout counter
module change_return_engine #(
  parameter int NUM_COINS   = 3,
  parameter int TOTAL_BITS  = 16,
  parameter int WAIT_CYCLES = 100,
  parameter logic [NUM_COINS*TOTAL_BITS-1:0] COIN_VALS =
    {TOTAL_BITS'(1000), TOTAL_BITS'(500), TOTAL_BITS'(100)}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_COINS-1:0]  i_coin_in,
  input  logic                  i_activity,
  input  logic                  i_trigger_return,
  input  logic [TOTAL_BITS-1:0] i_total,
  input  logic                  i_return_ready,
  output logic [NUM_COINS-1:0]  o_return_coin,
  output logic                  o_return_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [TOTAL_BITS-1:0] o_residual,
  output logic [31:0]           o_wait_time
);

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    DONE
  } state_t;

  localparam logic [31:0] WAIT_RELOAD = 32'(WAIT_CYCLES);

  state_t                state_q, state_d;
  logic [TOTAL_BITS-1:0] remaining_q, remaining_d;
  logic [TOTAL_BITS-1:0] residual_q, residual_d;
  logic [31:0]           waitTime_q, waitTime_d;

  logic                  selValid;
  logic [TOTAL_BITS-1:0] selVal;
  logic [NUM_COINS-1:0]  selOneHot;
  logic                  activity;

  assign activity = (|i_coin_in) || i_activity;

  // Pick the largest coin not exceeding the remaining amount. Coin values
  // ascend with the index, so the last matching index is the largest coin.
  always_comb begin
    selValid  = 1'b0;
    selVal    = '0;
    selOneHot = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (COIN_VALS[k*TOTAL_BITS +: TOTAL_BITS] <= remaining_q) begin
        selValid     = 1'b1;
        selVal       = COIN_VALS[k*TOTAL_BITS +: TOTAL_BITS];
        selOneHot    = '0;
        selOneHot[k] = 1'b1;
      end
    end
  end

  // State and datapath registers; reset abandons any sequence in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      residual_q  <= '0;
      waitTime_q  <= WAIT_RELOAD;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      residual_q  <= residual_d;
      waitTime_q  <= waitTime_d;
    end
  end

  // Next-state logic. The residual is captured on the way into DONE so that
  // it is already visible while o_done is high. Subtraction only happens when
  // a coin was selected, and a selected coin never exceeds remaining_q.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    residual_d  = residual_q;
    waitTime_d  = waitTime_q;
    case (state_q)
      IDLE: begin
        if ((i_total == '0) || activity) begin
          waitTime_d = WAIT_RELOAD;
        end else if (waitTime_q != 32'd0) begin
          waitTime_d = waitTime_q - 32'd1;
        end
        if (i_trigger_return || ((waitTime_q == 32'd0) && (i_total != '0))) begin
          state_d     = DISPENSE;
          remaining_d = i_total;
        end
      end
      DISPENSE: begin
        if (selValid) begin
          if (i_return_ready) begin
            remaining_d = remaining_q - selVal;
          end
        end else begin
          state_d    = DONE;
          residual_d = remaining_q;
        end
      end
      DONE: begin
        waitTime_d = WAIT_RELOAD;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_return_valid = (state_q == DISPENSE) && selValid;
  assign o_return_coin  = o_return_valid ? selOneHot : '0;
  assign o_busy         = (state_q == DISPENSE) || (state_q == DONE);
  assign o_done         = (state_q == DONE);
  assign o_residual     = residual_q;
  assign o_wait_time    = waitTime_q;

endmodule

// File: tb/tb_change_return_engine.sv
// tb_change_return_engine
//
// Directed bench for change_return_engine. Stimulus pushes the coins and
// residuals it expects into a scoreboard queue; an independent monitor pops
// and compares each accepted coin and each o_done pulse.
module tb_change_return_engine;

  localparam int NC = 3;
  localparam int TB = 16;

  logic          clk;
  logic          reset_n;
  logic [NC-1:0] i_coin_in;
  logic          i_activity;
  logic          i_trigger_return;
  logic [TB-1:0] i_total;
  logic          i_return_ready;
  logic [NC-1:0] o_return_coin;
  logic          o_return_valid;
  logic          o_busy;
  logic          o_done;
  logic [TB-1:0] o_residual;
  logic [31:0]   o_wait_time;

  int checks;
  int failures;

  typedef struct {
    bit          isDone;
    logic [15:0] value;
  } exp_t;

  exp_t sbQ[$];

  change_return_engine #(
    .NUM_COINS  (NC),
    .TOTAL_BITS (TB),
    .WAIT_CYCLES(4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_coin_in       (i_coin_in),
    .i_activity      (i_activity),
    .i_trigger_return(i_trigger_return),
    .i_total         (i_total),
    .i_return_ready  (i_return_ready),
    .o_return_coin   (o_return_coin),
    .o_return_valid  (o_return_valid),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_residual      (o_residual),
    .o_wait_time     (o_wait_time)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushCoin(input logic [15:0] oneHot);
    exp_t e;
    e.isDone = 1'b0;
    e.value  = oneHot;
    sbQ.push_back(e);
  endtask

  task automatic pushDone(input logic [15:0] residual);
    exp_t e;
    e.isDone = 1'b1;
    e.value  = residual;
    sbQ.push_back(e);
  endtask

  // Issue a one-cycle return request, optionally alongside a coin strobe,
  // then drop i_total to zero to show it is ignored once dispensing starts.
  task automatic applyStimulus(input logic [TB-1:0] total, input logic [NC-1:0] coinStrobe);
    i_total          = total;
    i_trigger_return = 1'b1;
    i_coin_in        = coinStrobe;
    tick();
    i_trigger_return = 1'b0;
    i_coin_in        = '0;
    i_total          = '0;
  endtask

  task automatic waitDone(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
    tick();
  endtask

  // Scoreboard monitor: every accepted coin and every o_done pulse must match
  // the next queued expectation; an idle coin bus must be zero.
  always @(negedge clk) begin
    exp_t e;
    if (o_return_valid && i_return_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_coin", 32'(o_return_coin), 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_kind_coin", 32'(e.isDone), 32'd0);
        checkOutput("sb_coin", 32'(o_return_coin), 32'(e.value));
      end
    end
    if (o_done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(o_done), 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_kind_done", 32'(e.isDone), 32'd1);
        checkOutput("sb_residual", 32'(o_residual), 32'(e.value));
      end
    end
    if (!o_return_valid) begin
      checkOutput("idle_coin_zero", 32'(o_return_coin), 32'd0);
    end
  end

  initial begin
    reset_n          = 1'b0;
    i_coin_in        = '0;
    i_activity       = 1'b0;
    i_trigger_return = 1'b0;
    i_total          = '0;
    i_return_ready   = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_valid", 32'(o_return_valid), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    checkOutput("rst_residual", 32'(o_residual), 32'd0);
    checkOutput("rst_wait", o_wait_time, 32'd4);
    tick();
    reset_n = 1'b1;
    tick();

    // 1700 -> 1000, 500, 100, 100, residual 0
    $display("[TB] return 1700");
    pushCoin(16'b100); pushCoin(16'b010); pushCoin(16'b001); pushCoin(16'b001);
    pushDone(16'd0);
    applyStimulus(16'd1700, 3'b000);
    waitDone("t1700", 20);
    checkOutput("t1700_wait_reload", o_wait_time, 32'd4);

    // 1750 -> 1000, 500, 100, 100, residual 50
    $display("[TB] return 1750");
    pushCoin(16'b100); pushCoin(16'b010); pushCoin(16'b001); pushCoin(16'b001);
    pushDone(16'd50);
    applyStimulus(16'd1750, 3'b000);
    waitDone("t1750", 20);
    checkOutput("t1750_residual_held", 32'(o_residual), 32'd50);

    // Reset after the first 1000 of 1700 is accepted: no further coins, no done
    $display("[TB] reset mid-dispense");
    pushCoin(16'b100);
    applyStimulus(16'd1700, 3'b000);
    @(posedge clk);
    #1;
    reset_n        = 1'b0;
    i_return_ready = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("midrst_busy", 32'(o_busy), 32'd0);
    checkOutput("midrst_valid", 32'(o_return_valid), 32'd0);
    checkOutput("midrst_coin", 32'(o_return_coin), 32'd0);
    checkOutput("midrst_done", 32'(o_done), 32'd0);
    checkOutput("midrst_residual", 32'(o_residual), 32'd0);
    checkOutput("midrst_wait", o_wait_time, 32'd4);
    tick();
    reset_n        = 1'b1;
    i_return_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    checkOutput("midrst_queue_empty", 32'(sbQ.size()), 32'd0);

    // 600 with ready low for three cycles: coin 500 held, then 500, 100
    $display("[TB] stalled return 600");
    pushCoin(16'b010); pushCoin(16'b001); pushDone(16'd0);
    i_return_ready = 1'b0;
    applyStimulus(16'd600, 3'b000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(o_return_valid), 32'd1);
      checkOutput("stall_coin", 32'(o_return_coin), 32'b010);
      checkOutput("stall_busy", 32'(o_busy), 32'd1);
      tick();
    end
    i_return_ready = 1'b1;
    waitDone("t600", 20);

    // Idle timeout with credit 100: 4,3,2,1,0 then coin 100
    $display("[TB] idle timeout");
    pushCoin(16'b001); pushDone(16'd0);
    i_total = 16'd100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("timeout_count", o_wait_time, 32'(4 - c));
      checkOutput("timeout_idle", 32'(o_busy), 32'd0);
      tick();
    end
    i_total = '0;
    waitDone("timeout", 20);

    // Coin strobe at count 2 reloads the counter instead of timing out
    $display("[TB] activity reload");
    i_total = 16'd100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("reload_count", o_wait_time, 32'(4 - c));
      if (c < 2) tick();
    end
    i_coin_in = 3'b001;
    tick();
    i_coin_in = '0;
    @(negedge clk);
    checkOutput("reload_back_to_4", o_wait_time, 32'd4);
    checkOutput("reload_not_busy", 32'(o_busy), 32'd0);
    i_total = '0;
    tick();

    // Trigger and coin strobe together with 500: trigger wins
    $display("[TB] trigger with strobe");
    pushCoin(16'b010); pushDone(16'd0);
    applyStimulus(16'd500, 3'b100);
    waitDone("t500", 20);

    // Trigger with zero credit: no coins, done with residual 0
    $display("[TB] zero credit");
    pushDone(16'd0);
    applyStimulus(16'd0, 3'b000);
    waitDone("tzero", 10);

    tick();
    checkOutput("final_queue_empty", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
